bus_arbiter: RTL
================

# bus_arbiter

Two-master arbiter placed in front of the shared `BUS` master port. It accepts requests from master 0 and master 1, grants ownership to one at a time using round-robin tie-break and a bounded hold time, and drives the single `BUS` master-side port (`m_req`, `m_wr`, `m_addr`, `m_dout`) from the current owner. Read data from `BUS` (`m_din`) is returned only to the owner, so two masters can share slaves 0 and 1 without protocol changes inside `BUS`.

## Interface
- `ADDR_W`, 16: address width, matches `BUS` `m_addr`.
- `DATA_W`, 64: data width, matches `BUS` `m_dout`/`m_din`.
- `MAX_HOLD`, 8: max consecutive contended cycles an owner keeps the bus (≥2).

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  master request, held high for the whole access/burst.
- `m0_wr`, `m1_wr`  in  1  write enable from master.
- `m0_addr`, `m1_addr`  in  ADDR_W  master address.
- `m0_dout`, `m1_dout`  in  DATA_W  master write data.
- `m0_grant`, `m1_grant`  out  1  registered ownership flag.
- `m0_din`, `m1_din`  out  DATA_W  read data to master, 0 when not owner.
- `m_req`  out  1  to `BUS` `m_req`.
- `m_wr`  out  1  to `BUS` `m_wr`.
- `m_addr`  out  ADDR_W  to `BUS` `m_addr`.
- `m_dout`  out  DATA_W  to `BUS` `m_dout`.
- `m_din`  in  DATA_W  from `BUS` `m_din`.

## Operation
- States: IDLE, OWN0, OWN1. `m0_grant` = (state==OWN0), `m1_grant` = (state==OWN1), both registered.
- `last` pointer (1 bit) = most recently granted master; `hold_cnt` width clog2(MAX_HOLD)+1.
- IDLE: only m0_req → OWN0; only m1_req → OWN1; both → master ≠ `last`; none → stay.
- OWNx, other master y:
  - mx_req=0, my_req=1 → OWNy directly (no idle gap).
  - mx_req=0, my_req=0 → IDLE.
  - mx_req=1, my_req=1, hold_cnt==MAX_HOLD-1 → OWNy (preemption).
  - mx_req=1, my_req=1, otherwise → stay, hold_cnt+1.
  - mx_req=1, my_req=0 → stay, hold_cnt←0 (only contended cycles count).
- Any state change: hold_cnt←0; `last` updates to the newly granted master on entry to OWNx.
- Bus-side mux (combinational from state): OWNx → m_req=mx_req, m_wr=mx_wr, m_addr=mx_addr, m_dout=mx_dout; IDLE → all 0.
- Read return: OWNx → mx_din=m_din, other din=0; IDLE → both 0.
- Preempted master sees grant drop; it must keep req high and will regain the bus on the next rotation.

## Timing
- Reset (synchronous, `reset`=1 at edge): state IDLE, `last`=1 (master 0 wins first tie), hold_cnt=0; all outputs 0 (grants, m_req, m_wr, m_addr, m_dout, m0_din, m1_din).
- Grant latency: req sampled high at edge N in IDLE → grant high after edge N (visible cycle N+1).
- Release: req low at edge N → grant low after edge N; handoff to waiting master in the same edge.
- Bus outputs follow state with zero added cycles; m_din forwarded combinationally.
- Preemption: under continuous contention each master owns exactly MAX_HOLD cycles, then swap on the next edge.
- Reset mid-ownership: next edge forces IDLE and zeroes outputs regardless of reqs; in-flight access is abandoned.
- Reqs asserted during reset are ignored; first grant is at the edge after reset deasserts.

## Test plan
- Reset: reset=1 for 2 cycles with m0_req=m1_req=1 → both grants 0, m_req=0, m_addr=0; first edge after reset → m0_grant=1.
- Single master: m1_req=1, m1_addr=16'd10, m1_wr=0, m_din=64'haaa → m1_grant=1 next cycle, m_addr=10, m1_din=64'haaa, m0_din=0.
- Direct handoff: OWN0, drop m0_req while m1_req=1 with m1_addr=16'd28965 → next cycle m1_grant=1, m0_grant=0, m_addr=28965, no IDLE cycle.
- Preemption: both reqs held high, MAX_HOLD=8 → grants alternate every 8 cycles (m0 first), m_dout tracks owner (64'd1111 vs 64'd2222).
- Round-robin tie: both request simultaneously from IDLE twice after m0 last owned → second arbitration grants m1.
- Reset mid-write: OWN1 with m1_wr=1, m1_dout=64'd7777, assert reset → next edge m_wr=0, m_dout=0, m1_grant=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single bus master port.
// Owner is held for at most MAX_HOLD contended cycles before rotation.
module bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    // One-hot-ish encoding so each grant is a flop bit directly.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0]    state;
    logic [1:0]    nxt_state;
    logic [1:0]    other;
    logic          last;
    logic          nxt_last;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] nxt_hold;
    logic          own_req;
    logic          oth_req;

    // State register: ownership, round-robin pointer and contention counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= nxt_state;
            last     <= nxt_last;
            hold_cnt <= nxt_hold;
        end
    end

    // Next-state: arbitration, release/handoff and preemption.
    always_comb begin
        nxt_state = state;
        nxt_hold  = '0;
        own_req   = 1'b0;
        oth_req   = 1'b0;
        other     = IDLE;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    nxt_state = last ? OWN0 : OWN1;
                end else if (m0_req) begin
                    nxt_state = OWN0;
                end else if (m1_req) begin
                    nxt_state = OWN1;
                end
            end
            OWN0: begin
                own_req = m0_req;
                oth_req = m1_req;
                other   = OWN1;
            end
            OWN1: begin
                own_req = m1_req;
                oth_req = m0_req;
                other   = OWN0;
            end
            default: nxt_state = IDLE;
        endcase
        if (state != IDLE) begin
            if (!own_req) begin
                nxt_state = oth_req ? other : IDLE;
            end else if (oth_req) begin
                if (hold_cnt == HOLD_LAST) begin
                    nxt_state = other;
                end else begin
                    nxt_hold = hold_cnt + 1'b1;
                end
            end
        end
        nxt_last = last;
        if (nxt_state == OWN0 && state != OWN0) begin
            nxt_last = 1'b0;
        end else if (nxt_state == OWN1 && state != OWN1) begin
            nxt_last = 1'b1;
        end
    end

    assign m0_grant = state[0];
    assign m1_grant = state[1];

    // Output mux: bus side follows the owner, read data only to the owner.
    always_comb begin
        m_req  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_dout = '0;
        m0_din = '0;
        m1_din = '0;
        unique case (state)
            OWN0: begin
                m_req  = m0_req;
                m_wr   = m0_wr;
                m_addr = m0_addr;
                m_dout = m0_dout;
                m0_din = m_din;
            end
            OWN1: begin
                m_req  = m1_req;
                m_wr   = m1_wr;
                m_addr = m1_addr;
                m_dout = m1_dout;
                m1_din = m_din;
            end
            default: begin
            end
        endcase
    end

endmodule
